sqrt_seq: RTL

Sequential, parametrised integer square root built on the non-restoring digit recurrence of the combinational `sqrt_wrapper` datapath. It computes `floor(sqrt(num))` and the exact remainder. Cost is spread over multiple cycles at a selectable number of recurrence steps per clock, behind a valid/ready handshake on both sides. It sits between streaming DSP stages, for example magnitude computation after I²+Q².

---
 rtl/sqrt_seq.sv | 115 +++++++++++
 1 files changed

// File: rtl/sqrt_seq.sv
// Multi-cycle integer square root (non-restoring digit recurrence) with valid/ready handshakes.
// Produces floor(sqrt(num)) and the exact remainder num - result^2, STEPS recurrence steps per clock.
module sqrt_seq #(
    parameter int N     = 16,
    parameter int STEPS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     num,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N/2-1:0]   result,
    output logic [N/2:0]     remainder
);

    localparam int H     = N / 2;
    localparam int ITERS = N / (2 * ((STEPS > 0) ? STEPS : 1));
    localparam int CW    = (ITERS > 1) ? $clog2(ITERS) : 1;

    if (N < 4 || (N % 2) != 0 || STEPS < 1 || (H % ((STEPS > 0) ? STEPS : 1)) != 0) begin : g_bad_params
        $error("sqrt_seq: N must be even and >= 4, and STEPS must divide N/2");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state, state_nxt;
    logic [N-1:0]    a;
    logic [H-1:0]    q;
    logic [H+1:0]    r;
    logic [CW-1:0]   cnt;

    logic [N-1:0]    a_c;
    logic [H-1:0]    q_c;
    logic [H+1:0]    r_c;
    logic [H+1:0]    left, right;
    logic [H:0]      rem_fix;

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)      state_nxt = BUSY;
            BUSY:    if (cnt == '0)     state_nxt = DONE;
            DONE:    if (out_ready)     state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // NOTE: every variable gets a default before the loop, so no latch is inferred; blocking
    // assignments here chain the STEPS recurrence steps within one cycle.
    always_comb begin
        a_c   = a;
        q_c   = q;
        r_c   = r;
        left  = '0;
        right = '0;
        for (int i = 0; i < STEPS; i++) begin
            left  = {r_c[H-1:0], a_c[N-1:N-2]};
            right = {q_c, r_c[H+1], 1'b1};
            if (r_c[H+1]) r_c = left + right;
            else          r_c = left - right;
            q_c = {q_c[H-2:0], ~r_c[H+1]};
            a_c = a_c << 2;
        end
        // A negative final partial remainder is corrected by adding back {q,1}.
        rem_fix = r_c[H+1] ? (r_c[H:0] + {q_c, 1'b1}) : r_c[H:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a         <= '0;
            q         <= '0;
            r         <= '0;
            cnt       <= '0;
            result    <= '0;
            remainder <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a   <= num;
                        q   <= '0;
                        r   <= '0;
                        cnt <= CW'(ITERS - 1);
                    end
                end
                BUSY: begin
                    a <= a_c;
                    q <= q_c;
                    r <= r_c;
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        result    <= q_c;
                        remainder <= rem_fix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
